// File: rtl/adder_tree_pipe.sv
// Pipelined N-input adder tree with valid/ready flow control and a sideband tag.
// Ports: clk, rst_n (async, active-low); in_data/in_valid/in_ready/in_tag upstream;
//        out_data/out_valid/out_ready/out_tag downstream. Whole pipe stalls on backpressure.
module adder_tree_pipe #(
    parameter int NUM_IN     = 8,
    parameter int IN_BITS    = 16,
    parameter int SIGN_EXT   = 1,
    parameter int REG_STRIDE = 1,
    parameter int TAG_BITS   = 4,
    localparam int LEVELS    = $clog2(NUM_IN),
    localparam int OUT_BITS  = IN_BITS + LEVELS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IN*IN_BITS-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TAG_BITS-1:0]         in_tag,
    output logic [OUT_BITS-1:0]         out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TAG_BITS-1:0]         out_tag
);

    // Stride 0 means "last level only"; mapping it past LEVELS avoids a
    // modulo by zero and leaves only the forced final register.
    localparam int STR = (REG_STRIDE == 0) ? LEVELS + 1 : REG_STRIDE;

    function automatic int cnt(input int k);
        return (NUM_IN + (1 << k) - 1) >> k;
    endfunction

    logic en;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Operands are extended to the full output width up front; adding at
    // full width gives the same exact result as growing one bit per level.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int N = cnt(k);

        logic [OUT_BITS-1:0] s [N];
        logic                v;
        logic [TAG_BITS-1:0] t;

        if (k == 0) begin : g_in
            for (genvar i = 0; i < N; i++) begin : g_ext
                logic [IN_BITS-1:0] x;
                assign x = in_data[i*IN_BITS +: IN_BITS];
                if (SIGN_EXT != 0) begin : g_s
                    assign s[i] = {{LEVELS{x[IN_BITS-1]}}, x};
                end else begin : g_u
                    assign s[i] = {{LEVELS{1'b0}}, x};
                end
            end
            assign v = in_valid;
            assign t = in_tag;
        end else begin : g_add
            localparam int P = cnt(k - 1);

            logic [OUT_BITS-1:0] nxt [N];

            // An unpaired last element passes straight through.
            for (genvar i = 0; i < N; i++) begin : g_node
                if (2 * i + 1 < P) begin : g_pair
                    assign nxt[i] = g_lvl[k-1].s[2*i] + g_lvl[k-1].s[2*i+1];
                end else begin : g_odd
                    assign nxt[i] = g_lvl[k-1].s[2*i];
                end
            end

            if ((k % STR == 0) || (k == LEVELS)) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v <= 1'b0;
                        t <= '0;
                        for (int i = 0; i < N; i++) s[i] <= '0;
                    end else if (en) begin
                        v <= g_lvl[k-1].v;
                        t <= g_lvl[k-1].t;
                        for (int i = 0; i < N; i++) s[i] <= nxt[i];
                    end
                end
            end else begin : g_comb
                assign v = g_lvl[k-1].v;
                assign t = g_lvl[k-1].t;
                for (genvar i = 0; i < N; i++) begin : g_pass
                    assign s[i] = nxt[i];
                end
            end
        end
    end

    assign out_data  = g_lvl[LEVELS].s[0];
    assign out_valid = g_lvl[LEVELS].v;
    assign out_tag   = g_lvl[LEVELS].t;

endmodule
